mp_dcache_assoc: RTL
====================

MP_DCACHE_ASSOC -- requirements
Module: mp_dcache_assoc

Interface
REQ-001 Parameter WAYS, default 2: associativity; legal 1, 2, 4.
REQ-002 Parameter SETS, default 32: sets per way; power of 2, 4..256.
REQ-003 Parameter ADDR_W, default 16: byte address width; line is fixed at 16 bytes (128 bits).
REQ-004 sys_clk  in  1  clock, all state on rising edge.
REQ-005 sys_rst  in  1  reset, asynchronous, active-high.
REQ-006 issue  in  1  core request valid; accepted when stall=0.
REQ-007 rwn  in  1  1=load, 0=store.
REQ-008 addr  in  ADDR_W  byte address; word-aligned.
REQ-009 bmask  in  4  store byte enables within the addressed word.
REQ-010 wdata  in  32  store data.
REQ-011 stall  out  1  core must hold off issue.
REQ-012 wb  out  1  load data valid, one-cycle pulse.
REQ-013 wb_data  out  32  load data.
REQ-014 invd_req / invd_adr  in  1 / ADDR_W  line invalidate request and address.
REQ-015 invd_ack  out  1  invalidate accepted this cycle.
REQ-016 mem_request  out  1  memory transaction, held high until mem_finish.
REQ-017 mem_rwn  out  1  1=line fill, 0=line write-back.
REQ-018 mem_addr  out  ADDR_W  line address, low 4 bits zero.
REQ-019 mem_wdata  out  128  write-back line.
REQ-020 mem_finish  in  1  one-cycle completion pulse.
REQ-021 mem_rdata  in  128  fill line, valid with mem_finish when mem_rwn=1.

Function
REQ-022 Address split: offset [3:0], set index [4+log2(SETS)-1:4], tag = remaining upper bits.
REQ-023 FSM states IDLE, LOOKUP, EVICT, FILL, FINISH; accepted issue moves IDLE->LOOKUP.
REQ-024 LOOKUP hit (valid and tag match in any way): loads assert wb with data in that cycle; stores merge bmask bytes and set dirty; stall=0; next state IDLE, or LOOKUP if a new issue is accepted.
REQ-025 LOOKUP miss: stall=1 combinationally in that cycle; victim = first invalid way (lowest index), else replacement policy; dirty victim -> EVICT, else -> FILL.
REQ-026 EVICT: mem_request=1, mem_rwn=0, mem_addr={victim tag, set, 4'b0}, mem_wdata=victim line; on mem_finish -> FILL.
REQ-027 FILL: mem_request=1, mem_rwn=1, mem_addr={req tag, set, 4'b0}; on mem_finish write mem_rdata, tag, valid=1, dirty=0 into victim -> FINISH.
REQ-028 FINISH: replay the access as a hit (load wb pulse, or store merge with dirty=1), stall=0, -> IDLE; miss-to-wb latency is therefore one cycle after the final mem_finish.
REQ-029 mem_request deasserts in the cycle after mem_finish; no back-to-back requests without one idle cycle.
REQ-030 Every hit and every fill updates replacement state for the set.
REQ-031 Invalidate accepted (invd_ack=1) only in IDLE with issue=0; the matching way's valid and dirty bits clear next cycle; dirty data is discarded; no match is a no-op.
REQ-032 issue and invd_req in the same cycle: issue wins, invd_ack=0.
REQ-033 wb=0 in all states other than a LOOKUP load hit or a FINISH load.

Reset
REQ-034 On sys_rst: all valid, dirty and replacement bits = 0, FSM = IDLE, stall = 0, wb = 0, invd_ack = 0, mem_request = 0; line and tag storage is not cleared.
REQ-035 Reset mid-transaction abandons the transaction; mem_request falls immediately and the memory side tolerates it.

Configuration
REQ-036 With DCACHE_PLRU_EN defined: tree pseudo-LRU per set, WAYS-1 bits.
REQ-037 Without DCACHE_PLRU_EN: a single global log2(WAYS)-bit round-robin counter advances on each fill; with WAYS=1 both choices select way 0.

Structure
REQ-038 Shared package holds FSM state encodings, LINE_BYTES=16, and the load/store op constants.
REQ-039 Sub-module mp_dcache_way: one way's tag/data array plus valid/dirty vectors, instantiated WAYS times.

Verification
REQ-040 Reset, then load 0x0100 -> FILL with mem_addr=0x0100; mem_rdata word0=0xDEADBEEF -> wb=1, wb_data=0xDEADBEEF one cycle after mem_finish.
REQ-041 Store 0x0104 bmask=4'b0011 wdata=0x1234_5678, then load 0x0104 -> hit, no mem_request, wb_data low half=0x5678.
REQ-042 WAYS=2: dirty 0x0100, then fill 0x2100 and 0x4100 in the same set -> EVICT writes back the LRU line (0x0100 under PLRU) before FILL.
REQ-043 invd_req 0x2100 with issue=0 in IDLE -> invd_ack=1; a following load 0x2100 misses.
REQ-044 issue and invd_req asserted together -> invd_ack=0, and the load completes normally.
REQ-045 sys_rst pulsed during FILL -> mem_request=0 and stall=0 immediately; the next load of the same address misses.

Source files
------------

// File: rtl/mp_dcache_assoc_pkg.sv
// Shared definitions for the set-associative data cache: FSM states, line geometry,
// load/store op codes, the store byte-merge helper and tree pseudo-LRU helpers.
package mp_dcache_assoc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_EVICT  = 3'd2,
    ST_FILL   = 3'd3,
    ST_FINISH = 3'd4
  } dc_state_e;

  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);

  localparam logic OP_LOAD  = 1'b1;
  localparam logic OP_STORE = 1'b0;

  // Overwrite the enabled bytes of one 32-bit word inside a line.
  function automatic logic [LINE_W-1:0] merge_line(
    input logic [LINE_W-1:0] line,
    input logic [1:0]        word,
    input logic [3:0]        be,
    input logic [31:0]       data
  );
    logic [LINE_W-1:0] r;
    r = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[{word, 5'd0} + 7'(b * 8) +: 8] = data[b*8 +: 8];
    end
    return r;
  endfunction

  // Tree PLRU victim: bit0 chooses the half, bit1/bit2 choose within the left/right pair.
  function automatic logic [1:0] plru_victim(input logic [2:0] bits, input int ways);
    logic [1:0] v;
    v = 2'd0;
    if (ways == 4)      v = bits[0] ? (bits[2] ? 2'd3 : 2'd2) : (bits[1] ? 2'd1 : 2'd0);
    else if (ways == 2) v = {1'b0, bits[0]};
    return v;
  endfunction

  // Point every tree node on the path to the touched way away from it.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way,
                                            input int ways);
    logic [2:0] r;
    r = bits;
    if (ways == 4) begin
      r[0] = ~way[1];
      if (!way[1]) r[1] = ~way[0];
      else         r[2] = ~way[0];
    end else if (ways == 2) begin
      r[0] = ~way[0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mp_dcache_way.sv
// One cache way: tag and line arrays (not reset) plus per-set valid/dirty vectors.
// Latency: reads are combinational, writes and invalidates take effect at the next edge.
// Backpressure: none; the owning controller sequences all accesses.
module mp_dcache_way
  import mp_dcache_assoc_pkg::*;
#(
  parameter int SETS  = 32,
  parameter int TAG_W = 7,
  parameter int SET_W = $clog2(SETS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [SET_W-1:0]  rd_set,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              rd_dirty,
  input  logic              wr_en,
  input  logic [SET_W-1:0]  wr_set,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              wr_dirty,
  input  logic              inv_en,
  input  logic [SET_W-1:0]  inv_set
);

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];
  logic [SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]   dirty_q, dirty_d;

  assign rd_tag   = tag_mem[rd_set];
  assign rd_data  = data_mem[rd_set];
  assign rd_vld   = valid_q[rd_set];
  assign rd_dirty = dirty_q[rd_set];

  // A write always leaves the line valid; an invalidate drops valid and dirty together.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      valid_d[wr_set] = 1'b1;
      dirty_d[wr_set] = wr_dirty;
    end
    if (inv_en) begin
      valid_d[inv_set] = 1'b0;
      dirty_d[inv_set] = 1'b0;
    end
  end

  // State bits are cleared by reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and line storage keep their contents across reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      tag_mem[wr_set]  <= wr_tag;
      data_mem[wr_set] <= wr_data;
    end
  end

endmodule

// File: rtl/mp_dcache_assoc.sv
// Set-associative write-back data cache, 16-byte lines; DCACHE_PLRU_EN selects per-set tree
// PLRU, otherwise a global round-robin victim counter. Latency: hit wb in the cycle after
// issue; miss wb one cycle after the last mem_finish. Backpressure: stall holds off issue.
module mp_dcache_assoc
  import mp_dcache_assoc_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 32,
  parameter int ADDR_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              issue,
  input  logic              rwn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        bmask,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              wb,
  output logic [31:0]       wb_data,
  input  logic              invd_req,
  input  logic [ADDR_W-1:0] invd_adr,
  output logic              invd_ack,
  output logic              mem_request,
  output logic              mem_rwn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic              mem_finish,
  input  logic [127:0]      mem_rdata
);

  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - SET_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  dc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_rwn_q, req_rwn_d;
  logic [3:0]        req_bmask_q, req_bmask_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              gap_q, gap_d;

  logic [SET_W-1:0]  req_set, invd_set, rd_set;
  logic [TAG_W-1:0]  req_tag, invd_tag, cmp_tag;

  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_data [WAYS];
  logic [WAYS-1:0]   way_vld, way_dirty, way_match, way_wr_en, way_inv_en;

  logic              hit_any;
  logic [WAY_W-1:0]  hit_way, pick_way, policy_way, sel_way, touch_way;
  logic              touch_en, fill_evt, fin, wr_dirty;
  logic [LINE_W-1:0] sel_line, merged, wr_data;
  logic              unused_bits;

  assign req_set  = req_addr_q[OFF_W +: SET_W];
  assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
  assign invd_set = invd_adr[OFF_W +: SET_W];
  assign invd_tag = invd_adr[ADDR_W-1 -: TAG_W];

  // While idle the shared read port serves invalidate lookups, otherwise the held request.
  assign rd_set  = (state_q == ST_IDLE) ? invd_set : req_set;
  assign cmp_tag = (state_q == ST_IDLE) ? invd_tag : req_tag;

  assign unused_bits = ^{req_addr_q[1:0], invd_adr[OFF_W-1:0]};

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    mp_dcache_way #(
      .SETS  (SETS),
      .TAG_W (TAG_W),
      .SET_W (SET_W)
    ) u_way (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .rd_set   (rd_set),
      .rd_tag   (way_tag[g]),
      .rd_data  (way_data[g]),
      .rd_vld   (way_vld[g]),
      .rd_dirty (way_dirty[g]),
      .wr_en    (way_wr_en[g]),
      .wr_set   (req_set),
      .wr_tag   (req_tag),
      .wr_data  (wr_data),
      .wr_dirty (wr_dirty),
      .inv_en   (way_inv_en[g]),
      .inv_set  (invd_set)
    );
  end

  // Tag compare in every way; lowest matching way wins, lowest invalid way is preferred victim.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    pick_way = policy_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_match[w] = way_vld[w] && (way_tag[w] == cmp_tag);
      if (way_match[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_vld[w]) pick_way = WAY_W'(w);
    end
  end

  assign sel_way  = (state_q == ST_LOOKUP) ? hit_way : victim_q;
  assign sel_line = way_data[sel_way];
  assign wb_data  = sel_line[{req_addr_q[3:2], 5'd0} +: 32];
  assign merged   = merge_line(sel_line, req_addr_q[3:2], req_bmask_q, req_wdata_q);

  // The cycle after a completion keeps the request low so transactions never run back to back.
  assign mem_request = ((state_q == ST_EVICT) || (state_q == ST_FILL)) && !gap_q;
  assign mem_rwn     = (state_q != ST_EVICT);
  assign mem_addr    = (state_q == ST_EVICT) ? {way_tag[victim_q], req_set, {OFF_W{1'b0}}}
                                             : {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata   = way_data[victim_q];
  assign fin         = mem_finish && mem_request;

`ifdef DCACHE_PLRU_EN
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  logic [PLRU_W-1:0] plru_q [SETS];
  logic [PLRU_W-1:0] plru_set_d;
  logic              unused_fill;

  assign unused_fill = fill_evt;
  assign policy_way  = WAY_W'(plru_victim(3'(plru_q[req_set]), WAYS));

  // New tree bits for the request's set after touching the accessed way.
  always_comb begin
    plru_set_d = PLRU_W'(plru_touch(3'(plru_q[req_set]), 2'(touch_way), WAYS));
  end

  // Per-set PLRU trees, updated on every hit and fill.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (touch_en) begin
      plru_q[req_set] <= plru_set_d;
    end
  end
`else
  logic [WAY_W-1:0] rr_q, rr_d;
  logic             unused_touch;

  assign unused_touch = ^{touch_en, touch_way};
  assign policy_way   = rr_q;

  // Global round-robin pointer steps once per fill; a single way pins it at zero.
  always_comb begin
    rr_d = rr_q;
    if (fill_evt) rr_d = (WAYS == 1) ? '0 : rr_q + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

  // Controller: next state, stall/wb/ack strobes, array writes and request capture.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_rwn_d   = req_rwn_q;
    req_bmask_d = req_bmask_q;
    req_wdata_d = req_wdata_q;
    victim_d    = victim_q;
    gap_d       = fin;
    stall       = 1'b0;
    wb          = 1'b0;
    invd_ack    = 1'b0;
    way_wr_en   = '0;
    wr_data     = merged;
    wr_dirty    = 1'b1;
    touch_en    = 1'b0;
    touch_way   = hit_way;
    fill_evt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        invd_ack = invd_req && !issue;
        if (issue) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit_any) begin
          if (req_rwn_q == OP_LOAD) wb = 1'b1;
          else                      way_wr_en[hit_way] = 1'b1;
          touch_en = 1'b1;
          state_d  = issue ? ST_LOOKUP : ST_IDLE;
        end else begin
          stall    = 1'b1;
          victim_d = pick_way;
          state_d  = (way_vld[pick_way] && way_dirty[pick_way]) ? ST_EVICT : ST_FILL;
        end
      end
      ST_EVICT: begin
        stall = 1'b1;
        if (fin) state_d = ST_FILL;
      end
      ST_FILL: begin
        stall = 1'b1;
        if (fin) begin
          way_wr_en[victim_q] = 1'b1;
          wr_data   = mem_rdata;
          wr_dirty  = 1'b0;
          fill_evt  = 1'b1;
          touch_en  = 1'b1;
          touch_way = victim_q;
          state_d   = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (req_rwn_q == OP_LOAD) wb = 1'b1;
        else                      way_wr_en[victim_q] = 1'b1;
        state_d = issue ? ST_LOOKUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Any cycle with stall low accepts a new request into the holding registers.
    if (issue && !stall) begin
      req_addr_d  = addr;
      req_rwn_d   = rwn;
      req_bmask_d = bmask;
      req_wdata_d = wdata;
    end

    for (int w = 0; w < WAYS; w++) way_inv_en[w] = invd_ack && way_match[w];
  end

  // Controller registers; reset abandons any transaction in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_rwn_q   <= 1'b0;
      req_bmask_q <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_rwn_q   <= req_rwn_d;
      req_bmask_q <= req_bmask_d;
      req_wdata_q <= req_wdata_d;
      victim_q    <= victim_d;
      gap_q       <= gap_d;
    end
  end

endmodule
